// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ready handshake to
// instruction memory and drives the IF/ID register. A one-entry skid buffer
// holds a word that lands while decode is stalled, and a DROP state waits out
// a request whose word is no longer wanted after a redirect.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_wr_en,
    input  logic [ADDR_WIDTH-1:0] pc_wr_data,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetchState_t;

    // One captured fetch response: where it came from and what it was.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetchEntry_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    fetchState_t           state;
    fetchState_t           stateNext;
    fetchEntry_t           skid;
    fetchEntry_t           skidNext;
    logic [ADDR_WIDTH-1:0] dropAddr;
    logic [ADDR_WIDTH-1:0] dropAddrNext;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic                  ifValidNext;
    logic [ADDR_WIDTH-1:0] ifPcNext;
    logic [DATA_WIDTH-1:0] ifInstrNext;
    logic [ADDR_WIDTH-1:0] redirectTarget;
    logic [ADDR_WIDTH-1:0] pcPlus4;
    logic                  transfer;

    // Memory-side outputs depend only on state; DROP keeps presenting the
    // address of the abandoned request so the handshake stays stable.
    always_comb begin
        imem_req  = (state == FETCH) || (state == DROP);
        imem_addr = (state == DROP) ? dropAddr : pc;
    end

    // Handshake qualification and PC arithmetic (pc+4 wraps naturally).
    always_comb begin
        transfer       = imem_req & imem_ready;
        pcPlus4        = pc + PC_STEP;
        redirectTarget = pc_wr_data & ALIGN_MASK;
    end

    // Next-state and next-register logic; everything holds unless a branch
    // below says otherwise. A redirect outranks stall and transfer.
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        ifValidNext  = if_valid;
        ifPcNext     = if_pc;
        ifInstrNext  = if_instr;
        skidNext     = skid;
        dropAddrNext = dropAddr;

        if (pc_wr_en) begin
            pcNext      = redirectTarget;
            ifValidNext = 1'b0;
            ifInstrNext = NOP_INSTR;
            skidNext    = '0;
        end

        unique case (state)
            BOOT: begin
                stateNext = FETCH;
            end

            FETCH: begin
                if (pc_wr_en) begin
                    // An in-flight request must still complete; remember its
                    // address and discard its word in DROP.
                    if (!transfer) begin
                        dropAddrNext = pc;
                        stateNext    = DROP;
                    end
                end else if (transfer) begin
                    pcNext = pcPlus4;
                    if (!stall) begin
                        ifValidNext = 1'b1;
                        ifPcNext    = pc;
                        ifInstrNext = imem_rdata;
                    end else begin
                        skidNext.pc    = pc;
                        skidNext.instr = imem_rdata;
                        stateNext      = HOLD;
                    end
                end else if (!stall) begin
                    ifValidNext = 1'b0;
                end
            end

            HOLD: begin
                if (pc_wr_en) begin
                    stateNext = FETCH;
                end else if (!stall) begin
                    ifValidNext = 1'b1;
                    ifPcNext    = skid.pc;
                    ifInstrNext = skid.instr;
                    stateNext   = FETCH;
                end
            end

            DROP: begin
                if (transfer) begin
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    // State register; synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // PC, IF/ID register, skid buffer and drop address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
            skid     <= '0;
            dropAddr <= '0;
        end else begin
            pc       <= pcNext;
            if_valid <= ifValidNext;
            if_pc    <= ifPcNext;
            if_instr <= ifInstrNext;
            skid     <= skidNext;
            dropAddr <= dropAddrNext;
        end
    end

endmodule
